// File: rtl/arb2_rr_mux_stage_pkg.sv
// arb2_rr_mux_stage_pkg: shared constants for the two-source round-robin mux stage
//   SRC0/SRC1 : source indices, also the encoding of the mux select line
//   LP_RST    : reset value of the last-grant pointer (source 0 wins the first tie)
package arb2_rr_mux_stage_pkg;
    localparam logic SRC0   = 1'b0;
    localparam logic SRC1   = 1'b1;
    localparam logic LP_RST = SRC1;
endpackage

// File: rtl/arb2_rr_mux_stage_rr_grant2.sv
// rr_grant2: combinational two-way round-robin grant
//   v0, v1 : request valids
//   lp     : index of the source granted last
//   g      : granted source index (meaningful only when any=1)
//   any    : at least one request present
module rr_grant2
    import arb2_rr_mux_stage_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic lp,
    output logic g,
    output logic any
);
    // A tie goes to the source that did not win last; otherwise the lone requester.
    assign g   = (v0 && v1) ? ~lp : (v1 ? SRC1 : SRC0);
    assign any = v0 || v1;
endmodule

// File: rtl/arb2_rr_mux_stage.sv
// arb2_rr_mux_stage: registered two-source round-robin arbiter with one-entry output buffer
//   clk, clrn        : clock, asynchronous active-low clear
//   v0/d0/r0         : source 0 valid, data, ready
//   v1/d1/r1         : source 1 valid, data, ready
//   s                : source index of the word held in y (drives the mux2x1 select)
//   y_valid/y/y_ready: output word handshake to the consumer
module arb2_rr_mux_stage
    import arb2_rr_mux_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             v0,
    input  logic [WIDTH-1:0] d0,
    output logic             r0,
    input  logic             v1,
    input  logic [WIDTH-1:0] d1,
    output logic             r1,
    output logic             s,
    output logic             y_valid,
    output logic [WIDTH-1:0] y,
    input  logic             y_ready
);
    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             s_q, s_d;
    logic             lp_q, lp_d;
    logic             g, any, accept, xfer;

    rr_grant2 u_grant (
        .v0  (v0),
        .v1  (v1),
        .lp  (lp_q),
        .g   (g),
        .any (any)
    );

    // A full buffer being drained this cycle can take a new word in the same cycle.
    assign accept = !y_valid_q || y_ready;
    assign r0     = accept && any && (g == SRC0);
    assign r1     = accept && any && (g == SRC1);
    assign xfer   = (r0 && v0) || (r1 && v1);

    always_comb begin
        y_d       = xfer ? (g == SRC1 ? d1 : d0) : y_q;
        s_d       = xfer ? g : s_q;
        lp_d      = xfer ? g : lp_q;
        y_valid_d = xfer ? 1'b1 : (y_ready ? 1'b0 : y_valid_q);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            y_valid_q <= 1'b0;
            y_q       <= '0;
            s_q       <= SRC0;
            lp_q      <= LP_RST;
        end else begin
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
            s_q       <= s_d;
            lp_q      <= lp_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y       = y_q;
    assign s       = s_q;
endmodule

// File: tb/tb_arb2_rr_mux_stage.sv
// tb_arb2_rr_mux_stage: directed and randomized checks against a behavioural model
module tb_arb2_rr_mux_stage;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         clrn;
    logic         v0, v1, y_ready;
    logic [W-1:0] d0, d1;
    logic         r0, r1, s, y_valid;
    logic [W-1:0] y;

    int nerr = 0;
    int nchk = 0;

    // Model of the observable buffer: contents, its source, and who won last.
    bit           m_full;
    logic [W-1:0] m_word;
    int           m_src;
    int           m_last;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           took0, took1;
    logic [W-1:0] cnt0, cnt1;

    arb2_rr_mux_stage #(.WIDTH(W)) dut (
        .clk(clk), .clrn(clrn),
        .v0(v0), .d0(d0), .r0(r0),
        .v1(v1), .d1(d1), .r1(r1),
        .s(s), .y_valid(y_valid), .y(y), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_word = '0; m_src = 0; m_last = 1;
        q0.delete(); q1.delete();
    endtask

    // One clock cycle: inputs were driven just after the previous rising edge.
    task automatic cyc();
        bit room, req;
        int win;
        logic [W-1:0] front;
        @(negedge clk);
        room = !m_full || (y_ready === 1'b1);
        req  = v0 || v1;
        if (v0 && v1) win = (m_last == 1) ? 0 : 1;
        else win = v1 ? 1 : 0;
        chk("r0", {31'b0, r0}, {31'b0, room && req && win == 0});
        chk("r1", {31'b0, r1}, {31'b0, room && req && win == 1});
        if (m_full && y_ready) begin
            if (m_src == 0 ? q0.size() == 0 : q1.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else begin
                front = (m_src == 0) ? q0.pop_front() : q1.pop_front();
                chk("sb_word", y, front);
            end
        end
        took0 = room && req && win == 0 && v0;
        took1 = room && req && win == 1 && v1;
        if (took0) begin q0.push_back(d0); m_word = d0; m_src = 0; m_last = 0; m_full = 1; end
        else if (took1) begin q1.push_back(d1); m_word = d1; m_src = 1; m_last = 1; m_full = 1; end
        else if (m_full && y_ready) m_full = 0;
        @(posedge clk);
        #1;
        chk("y_valid", {31'b0, y_valid}, {31'b0, m_full});
        chk("y", y, m_word);
        chk("s", {31'b0, s}, m_src[W-1:0]);
    endtask

    initial begin
        clrn = 1'b0; v0 = 0; v1 = 0; d0 = '0; d1 = '0; y_ready = 0;
        model_reset();
        #3;
        chk("rst_y_valid", {31'b0, y_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_s", {31'b0, s}, 32'd0);
        #4 clrn = 1'b1;
        @(posedge clk); #1;

        // Both streaming: strict alternation starting with source 0.
        v0 = 1; d0 = 32'h11; v1 = 1; d1 = 32'h22; y_ready = 1;
        cyc(); chk("alt_y0", y, 32'h11); chk("alt_s0", {31'b0, s}, 32'd0);
        cyc(); chk("alt_y1", y, 32'h22); chk("alt_s1", {31'b0, s}, 32'd1);
        cyc(); chk("alt_y2", y, 32'h11); chk("alt_s2", {31'b0, s}, 32'd0);
        cyc();

        // Lone requester on source 1, then a tie goes to source 0.
        v0 = 0; d1 = 32'hA5;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("lone_y", y, 32'hA5); chk("lone_s", {31'b0, s}, 32'd1);
        end
        v0 = 1; d0 = 32'h33;
        cyc(); chk("tie_after_lone", {31'b0, s}, 32'd0);
        v0 = 0; v1 = 0;
        cyc();

        // Fill then stall for 4 cycles, then drain and refill together.
        v0 = 1; d0 = 32'h5; y_ready = 0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("stall_y", y, 32'h5); chk("stall_v", {31'b0, y_valid}, 32'd1);
        end
        d0 = 32'h6; y_ready = 1;
        cyc(); chk("refill_y", y, 32'h6);
        v0 = 0;
        cyc();

        // Single transfer then idle: valid for exactly one cycle, data held.
        v1 = 1; d1 = 32'h7;
        cyc(); chk("single_v", {31'b0, y_valid}, 32'd1);
        v1 = 0;
        cyc(); chk("single_drop", {31'b0, y_valid}, 32'd0); chk("single_hold", y, 32'h7);
        cyc();

        // Asynchronous clear while full.
        v0 = 1; d0 = 32'h99; y_ready = 0;
        cyc();
        v0 = 0;
        #2 clrn = 1'b0;
        #1;
        chk("arst_y_valid", {31'b0, y_valid}, 32'd0);
        chk("arst_y", y, 32'd0);
        chk("arst_s", {31'b0, s}, 32'd0);
        model_reset();
        #3 clrn = 1'b1;
        @(posedge clk); #1;
        v0 = 1; d0 = 32'h44; v1 = 1; d1 = 32'h55; y_ready = 1;
        cyc(); chk("arst_tie", {31'b0, s}, 32'd0);
        v0 = 0; v1 = 0;
        cyc();

        // Random back-pressure with both sources streaming tagged words.
        cnt0 = 32'h0000_0000; cnt1 = 32'h8000_0000;
        took0 = 0; took1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!v0 || took0) begin v0 = ($urandom_range(0, 3) != 0); if (v0) begin d0 = cnt0; cnt0++; end end
            if (!v1 || took1) begin v1 = ($urandom_range(0, 3) != 0); if (v1) begin d1 = cnt1; cnt1++; end end
            y_ready = ($urandom_range(0, 2) != 0);
            cyc();
            chk("s_tag", {31'b0, s}, {31'b0, y[W-1]});
        end
        v0 = 0; v1 = 0; y_ready = 1;
        cyc(); cyc();
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
